// File: rtl/spu_rf_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Pulls in nothing; imported by multi_port_register_file and rf_write_arbiter.
package spu_rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int unsigned RF_WIDTH  = 128;
    localparam int unsigned RF_DEPTH  = 128;
    localparam int unsigned RF_NUM_RD = 5;
    localparam int unsigned RF_NUM_WR = 2;
    localparam int unsigned RF_CNT_W  = 16;

endpackage

// File: rtl/rf_write_arbiter.sv
// Same-cycle write arbitration: lowest port index wins a shared address,
// every later enabled port on that address is flagged as a conflict loser.
module rf_write_arbiter
    import spu_rf_pkg::*;
#(
    parameter int unsigned NUM_WR = RF_NUM_WR,
    parameter int unsigned AW     = 7
) (
    input  logic [NUM_WR-1:0]         i_wr_en,
    input  logic [NUM_WR-1:0][AW-1:0] i_wr_addr,
    output logic [NUM_WR-1:0]         o_commit,
    output logic [NUM_WR-1:0]         o_conflict
);

    always_comb begin
        o_commit   = '0;
        o_conflict = '0;
        for (int i = 0; i < int'(NUM_WR); i++) begin
            logic v_hit;
            v_hit = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (i_wr_en[j] && (i_wr_addr[j] == i_wr_addr[i])) begin
                    v_hit = 1'b1;
                end
            end
            o_commit[i]   = i_wr_en[i] && !v_hit;
            o_conflict[i] = i_wr_en[i] &&  v_hit;
        end
    end

endmodule

// File: rtl/multi_port_register_file.sv
// NUM_RD async-read / NUM_WR write register file with hardware clear sweep,
// write-conflict arbitration and a saturating conflict counter. Define RF_BYPASS_EN to forward winning writes to reads.
module multi_port_register_file
    import spu_rf_pkg::*;
#(
    parameter  int unsigned WIDTH  = RF_WIDTH,
    parameter  int unsigned DEPTH  = RF_DEPTH,
    parameter  int unsigned NUM_RD = RF_NUM_RD,
    parameter  int unsigned NUM_WR = RF_NUM_WR,
    parameter  int unsigned CNT_W  = RF_CNT_W,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_clear_req,
    input  logic [NUM_RD-1:0][AW-1:0]    i_rd_addr,
    output logic [NUM_RD-1:0][WIDTH-1:0] o_rd_data,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]    i_wr_addr,
    input  logic [NUM_WR-1:0][WIDTH-1:0] i_wr_data,
    output logic [NUM_WR-1:0]            o_wr_conflict,
    output logic                         o_rf_ready,
    output logic [CNT_W-1:0]             o_conflict_cnt
);

    localparam int unsigned PCW   = $clog2(NUM_WR + 1);
    localparam int unsigned SUM_W = CNT_W + PCW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0]    PTR_LAST = AW'(DEPTH - 1);

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [AW-1:0]     r_clr_ptr;
    logic [AW-1:0]     w_clr_ptr_nxt;
    logic              r_rf_ready;
    logic [CNT_W-1:0]  r_conflict_cnt;
    logic [CNT_W-1:0]  w_conflict_cnt_nxt;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_ready;
    logic [NUM_WR-1:0] w_wr_en_gated;
    logic [NUM_WR-1:0] w_commit;
    logic [NUM_WR-1:0] w_conflict;
    logic [PCW-1:0]    w_popcnt;
    logic [SUM_W-1:0]  w_cnt_sum;

    assign w_ready       = (r_state == READY);
    assign w_wr_en_gated = w_ready ? i_wr_en : '0;

    rf_write_arbiter #(
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_arb (
        .i_wr_en    (w_wr_en_gated),
        .i_wr_addr  (i_wr_addr),
        .o_commit   (w_commit),
        .o_conflict (w_conflict)
    );

    // Clear-sweep FSM: a clear request always wins over sweep completion.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            CLEAR: begin
                if (i_clear_req) begin
                    w_clr_ptr_nxt = '0;
                end else if (r_clr_ptr == PTR_LAST) begin
                    w_state_nxt   = READY;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + AW'(1);
                end
            end
            READY: begin
                if (i_clear_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= CLEAR;
            r_clr_ptr  <= '0;
            r_rf_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_ptr  <= w_clr_ptr_nxt;
            r_rf_ready <= (w_state_nxt == READY);
        end
    end

    // Storage has no reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge i_clock) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_WR); i++) begin
                if (w_commit[i]) begin
                    r_mem[i_wr_addr[i]] <= i_wr_data[i];
                end
            end
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < int'(NUM_WR); i++) begin
            w_popcnt = w_popcnt + PCW'(w_conflict[i]);
        end
        w_cnt_sum          = SUM_W'(r_conflict_cnt) + SUM_W'(w_popcnt);
        w_conflict_cnt_nxt = (w_cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_cnt_sum[CNT_W-1:0];
    end

    // Counter survives clear requests; only reset zeroes it.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_conflict_cnt <= '0;
        end else begin
            r_conflict_cnt <= w_conflict_cnt_nxt;
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            logic [WIDTH-1:0] v_rd;
            v_rd = r_mem[i_rd_addr[k]];
`ifdef RF_BYPASS_EN
            // Winners target distinct addresses, so at most one port matches.
            for (int i = 0; i < int'(NUM_WR); i++) begin
                if (w_commit[i] && (i_wr_addr[i] == i_rd_addr[k])) begin
                    v_rd = i_wr_data[i];
                end
            end
`endif
            o_rd_data[k] = w_ready ? v_rd : '0;
        end
    end

    assign o_wr_conflict  = w_conflict;
    assign o_rf_ready     = r_rf_ready;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_multi_port_register_file.sv
// Scoreboard bench: stimulus pushes model-predicted outputs per cycle, a negedge monitor pops and compares.
module tb_multi_port_register_file;

    localparam int unsigned WIDTH  = 128;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned NUM_RD = 5;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic                         clk;
    logic                         rst_n;
    logic                         clear_req;
    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR-1:0][AW-1:0]    wr_addr;
    logic [NUM_WR-1:0][WIDTH-1:0] wr_data;
    logic [NUM_WR-1:0]            wr_conflict;
    logic                         rf_ready;
    logic [CNT_W-1:0]             conflict_cnt;

    multi_port_register_file #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_clear_req    (clear_req),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .o_wr_conflict  (wr_conflict),
        .o_rf_ready     (rf_ready),
        .o_conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_RD-1:0][WIDTH-1:0] rd;
        logic [NUM_WR-1:0]            conf;
        logic                         rdy;
        logic [CNT_W-1:0]             cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: whole-file zeroing plus a countdown to readiness.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_ready;
    int               m_cd;
    int               m_cnt;
    bit               in_reset;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < int'(NUM_RD); k++)
                check($sformatf("rd_data[%0d]", k), rd_data[k], e.rd[k]);
            check("wr_conflict", WIDTH'(wr_conflict), WIDTH'(e.conf));
            check("rf_ready", WIDTH'(rf_ready), WIDTH'(e.rdy));
            check("conflict_cnt", WIDTH'(conflict_cnt), WIDTH'(e.cnt));
        end
    end

    function automatic logic [WIDTH-1:0] rnd_data();
        return WIDTH'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic zero_model();
        for (int a = 0; a < int'(DEPTH); a++) m_mem[a] = '0;
    endtask

    task automatic step();
        exp_t             e;
        logic [WIDTH-1:0] win [int];
        int               nconf;
        nconf  = 0;
        e.rdy  = m_ready;
        e.cnt  = CNT_W'(m_cnt);
        e.conf = '0;
        if (m_ready) begin
            for (int i = 0; i < int'(NUM_WR); i++) begin
                if (wr_en[i]) begin
                    if (win.exists(int'(wr_addr[i]))) begin
                        e.conf[i] = 1'b1;
                        nconf++;
                    end else begin
                        win[int'(wr_addr[i])] = wr_data[i];
                    end
                end
            end
        end
        for (int k = 0; k < int'(NUM_RD); k++) begin
            e.rd[k] = '0;
            if (m_ready) begin
                e.rd[k] = m_mem[rd_addr[k]];
`ifdef RF_BYPASS_EN
                if (win.exists(int'(rd_addr[k]))) e.rd[k] = win[int'(rd_addr[k])];
`endif
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!in_reset) begin
            if (m_ready) begin
                foreach (win[a]) m_mem[a] = win[a];
                m_cnt = (m_cnt + nconf > CNT_MAX) ? CNT_MAX : m_cnt + nconf;
                if (clear_req) begin
                    zero_model();
                    m_ready = 1'b0;
                    m_cd    = DEPTH;
                end
            end else if (clear_req) begin
                m_cd = DEPTH;
            end else begin
                m_cd--;
                if (m_cd == 0) m_ready = 1'b1;
            end
        end
    endtask

    task automatic assert_reset();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        m_ready  = 1'b0;
        m_cnt    = 0;
        m_cd     = DEPTH;
        zero_model();
    endtask

    task automatic release_reset();
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0;
        wr_en     = '0;
        for (int k = 0; k < int'(NUM_RD); k++) rd_addr[k] = AW'($urandom_range(0, DEPTH - 1));
    endtask

    task automatic set_wr(input int p, input logic en, input int addr, input logic [WIDTH-1:0] data);
        wr_en[p]   = en;
        wr_addr[p] = AW'(addr);
        wr_data[p] = data;
    endtask

    task automatic read_all(input int addr);
        for (int k = 0; k < int'(NUM_RD); k++) rd_addr[k] = AW'(addr);
    endtask

    // Writes offered while the file is clearing must be dropped.
    task automatic sweep_with_junk(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            idle_inputs();
            set_wr(0, 1'b1, $urandom_range(0, 7), rnd_data());
            set_wr(1, 1'b1, $urandom_range(0, 7), rnd_data());
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] a_val, b_val;
        clear_req = 1'b0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        assert_reset();
        @(posedge clk);
        #1;
        repeat (3) step();

        // Reset release: readiness after exactly DEPTH edges
        release_reset();
        sweep_with_junk(DEPTH + 2);
        foreach (rd_addr[k]) rd_addr[k] = '0;
        idle_inputs();
        foreach (rd_addr[k]) rd_addr[k] = AW'(0);   step();
        read_all(63);  step();
        read_all(127); step();

        // Distinct addresses commit together
        a_val = rnd_data();
        b_val = rnd_data();
        idle_inputs();
        set_wr(0, 1'b1, 5, a_val);
        set_wr(1, 1'b1, 9, b_val);
        rd_addr[0] = AW'(5);
        rd_addr[1] = AW'(9);
        step();
        idle_inputs();
        rd_addr[0] = AW'(5);
        rd_addr[1] = AW'(9);
        step();

        // Same-address conflict, then saturate the counter
        for (int c = 0; c < CNT_MAX + 20; c++) begin
            idle_inputs();
            set_wr(0, 1'b1, 7, rnd_data());
            set_wr(1, 1'b1, 7, rnd_data());
            rd_addr[0] = AW'(7);
            step();
        end
        idle_inputs();
        rd_addr[0] = AW'(7);
        step();

        // Clear request wipes earlier contents and ignores writes
        idle_inputs();
        set_wr(0, 1'b1, 3, WIDTH'(32'h1234));
        step();
        idle_inputs();
        rd_addr[0] = AW'(3);
        clear_req  = 1'b1;
        step();
        sweep_with_junk(DEPTH + 2);
        idle_inputs();
        read_all(3);
        step();

        // Reset mid-sweep restarts the sweep
        idle_inputs();
        clear_req = 1'b1;
        step();
        sweep_with_junk(60);
        assert_reset();
        idle_inputs();
        repeat (2) step();
        release_reset();
        sweep_with_junk(DEPTH + 1);

        // Read during same-cycle write to the same address
        idle_inputs();
        set_wr(0, 1'b1, 4, rnd_data());
        step();
        idle_inputs();
        set_wr(0, 1'b1, 4, WIDTH'(8'hFF));
        read_all(4);
        step();
        idle_inputs();
        read_all(4);
        step();

        // Randomized traffic over a narrow address window
        for (int c = 0; c < 1500; c++) begin
            clear_req = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < int'(NUM_RD); k++) rd_addr[k] = AW'($urandom_range(0, 15));
            for (int i = 0; i < int'(NUM_WR); i++)
                set_wr(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15), rnd_data());
            step();
        end

        idle_inputs();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
